// File: rtl/addsub_pkg.sv
// Shared definitions for the sequential add/sub unit: operand-select
// encodings, FSM state encoding and the per-bit B-operand select helper.
package addsub_pkg;

  // Operand-select encodings for the B input of the adder
  localparam logic [1:0] OP_ADD  = 2'b00;  // A + B
  localparam logic [1:0] OP_SUBN = 2'b01;  // A + ~B (A - B with cin=1)
  localparam logic [1:0] OP_PASS = 2'b10;  // A + 0
  localparam logic [1:0] OP_ALL1 = 2'b11;  // A + all-ones (A - 1 with cin=0)

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Selects one bit of the effective B operand for the given op code
  function automatic logic sel_bit(input logic [1:0] op_v, input logic b_v);
    logic r_v;
    r_v = b_v;
    case (op_v)
      OP_ADD:  r_v = b_v;
      OP_SUBN: r_v = ~b_v;
      OP_PASS: r_v = 1'b0;
      OP_ALL1: r_v = 1'b1;
      default: r_v = b_v;
    endcase
    return r_v;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational W-bit carry-lookahead adder slice. Every carry is formed
// directly from generate/propagate terms and the slice carry-in, so no
// carry ripples bit by bit. c_msb is the carry into the top bit of the
// slice, needed by the caller for signed-overflow detection.
module cla_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W-1:0] g_s;
  logic [W-1:0] p_s;
  logic [W:0]   c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  always_comb begin
    logic acc_v;
    logic term_v;
    acc_v  = 1'b0;
    term_v = 1'b0;
    c_s    = '0;
    c_s[0] = cin;
    for (int i = 0; i < W; i++) begin
      acc_v = cin;
      for (int k = 0; k <= i; k++) begin
        acc_v = acc_v & p_s[k];
      end
      for (int j = 0; j <= i; j++) begin
        term_v = g_s[j];
        for (int k = j + 1; k <= i; k++) begin
          term_v = term_v & p_s[k];
        end
        acc_v = acc_v | term_v;
      end
      c_s[i+1] = acc_v;
    end
  end

  assign sum   = p_s ^ c_s[W-1:0];
  assign cout  = c_s[W];
  assign c_msb = c_s[W-1];

endmodule

// File: rtl/seq_addsub_unit.sv
// Multi-cycle add/sub unit. A WIDTH-bit operation is processed one
// SLICE-bit lookahead slice per clock, LSB slice first, with the carry
// held in a register between slices. Valid/ready handshake on both sides.
// Optional build macro: ADDSUB_FLAGS_EN adds registered zero/neg outputs.
module seq_addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  parameter int CNT_W = ((WIDTH / SLICE) > 1) ? $clog2(WIDTH / SLICE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] b_sel_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef ADDSUB_FLAGS_EN
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
`endif

  logic [SLICE-1:0] sl_a_s;
  logic [SLICE-1:0] sl_b_s;
  logic [SLICE-1:0] sl_sum_s;
  logic             sl_cout_s;
  logic             sl_cmsb_s;

  // Bitwise effective-B select from the op code
  always_comb begin
    b_sel_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      b_sel_s[i] = sel_bit(op, b[i]);
    end
  end

  // Route the slice addressed by the counter into the shared adder
  always_comb begin
    sl_a_s = a_q[int'(cnt_q) * SLICE +: SLICE];
    sl_b_s = b_q[int'(cnt_q) * SLICE +: SLICE];
  end

  cla_slice #(
    .W (SLICE)
  ) u_cla_slice (
    .a     (sl_a_s),
    .b     (sl_b_s),
    .cin   (carry_q),
    .sum   (sl_sum_s),
    .cout  (sl_cout_s),
    .c_msb (sl_cmsb_s)
  );

  // Next-state and datapath-update logic for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef ADDSUB_FLAGS_EN
    zero_d      = zero_q;
    neg_d       = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b_sel_s;
          carry_d    = cin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      RUN: begin
        result_d[int'(cnt_q) * SLICE +: SLICE] = sl_sum_s;
        carry_d = sl_cout_s;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          // Carry into the MSB comes from inside the top slice
          cout_d      = sl_cout_s;
          ovf_d       = sl_cout_s ^ sl_cmsb_s;
`ifdef ADDSUB_FLAGS_EN
          zero_d      = (result_d == '0);
          neg_d       = result_d[WIDTH-1];
`endif
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          // Acceptance reopens only from the following cycle
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ADDSUB_FLAGS_EN
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ADDSUB_FLAGS_EN
      zero_q      <= zero_d;
      neg_q       <= neg_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
`ifdef ADDSUB_FLAGS_EN
  assign zero      = zero_q;
  assign neg       = neg_q;
`endif

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Directed, table-driven bench for seq_addsub_unit (WIDTH=16, SLICE=4).
// Optional build macro: ADDSUB_FLAGS_EN also checks zero/neg.
module tb_seq_addsub_unit;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  localparam int NVEC = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  op;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        ovf;
`ifdef ADDSUB_FLAGS_EN
  logic        zero;
  logic        neg;
`endif

  int compared   = 0;
  int mismatched = 0;
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  seq_addsub_unit #(
    .WIDTH (16),
    .SLICE (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
`ifdef ADDSUB_FLAGS_EN
    ,
    .zero      (zero),
    .neg       (neg)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operation at a negedge, scramble inputs, wait for out_valid
  task automatic start_op(input vec_t v, input string tag);
    int waitc;
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op  = v.op;
    a   = v.a;
    b   = v.b;
    cin = v.cin;
    @(negedge clk);
    in_valid = 1'b0;
    op  = ~v.op;
    a   = ~v.a;
    b   = 16'h5A5A;
    cin = ~v.cin;
  endtask

  task automatic wait_result(input vec_t v, input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " result"}, 32'(result), 32'(v.res));
    check({tag, " cout"}, 32'(cout), 32'(v.cout));
    check({tag, " ovf"}, 32'(ovf), 32'(v.ovf));
`ifdef ADDSUB_FLAGS_EN
    check({tag, " zero"}, 32'(zero), 32'(v.res == 16'h0000));
    check({tag, " neg"}, 32'(neg), 32'(v.res[15]));
`endif
  endtask

  task automatic run_op(input vec_t v, input string tag);
    start_op(v, tag);
    wait_result(v, tag);
    @(negedge clk);
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    //          op     a         b         cin   res       cout  ovf
    vecs[0]  = '{2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2]  = '{2'b10, 16'hFFFF, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{2'b11, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[4]  = '{2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5]  = '{2'b01, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{2'b00, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{2'b01, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[9]  = '{2'b00, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[10] = '{2'b10, 16'hABCD, 16'hFFFF, 1'b0, 16'hABCD, 1'b0, 1'b0};
    vecs[11] = '{2'b11, 16'h0000, 16'h0F0F, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 16'h0000;
    b         = 16'h0000;
    op        = 2'b00;
    cin       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
`ifdef ADDSUB_FLAGS_EN
    check("reset zero", 32'(zero), 32'd0);
    check("reset neg", 32'(neg), 32'd0);
`endif

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: hold out_ready low in DONE and pulse in_valid
    out_ready = 1'b0;
    v = '{2'b00, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
    start_op(v, "bp");
    wait_result(v, "bp");
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a = 16'hFFFF;
      b = 16'hFFFF;
      @(negedge clk);
      check($sformatf("bp hold result c%0d", k), 32'(result), 32'h0007);
      check($sformatf("bp hold valid c%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("bp hold in_ready c%0d", k), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("bp no stray op", 32'(in_ready), 32'd1);

    // Reset while slice 2 of an add is in progress
    v = '{2'b00, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    start_op(v, "rst");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst mid out_valid", 32'(out_valid), 32'd0);
    check("rst mid result", 32'(result), 32'd0);
    check("rst mid in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst abandoned", 32'(out_valid), 32'd0);
    v = '{2'b00, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    run_op(v, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
